// File: rtl/ge_fitness_scoreboard.sv
// ---------------------------------------------------------------------------
// ge_fitness_scoreboard
//
// Scores one evolved candidate datapath against golden vectors. Each accepted
// beat carries four candidate lanes (y3..y0) and four golden lanes (e3..e0).
// The XOR difference of every enabled lane is popcounted and added to a
// saturating error score. When NUM_VEC beats have been accepted and the
// pipeline has drained, done pulses for one cycle with the final score.
// Lower score is fitter; a score of 0 is a perfect individual.
//
// Valid/ready contract: a beat transfers on a rising edge where
// in_valid_i && in_ready_o. The source keeps data stable while
// in_valid_i && !in_ready_o. Idle gaps on in_valid_i are allowed anytime.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start_i             begin a run (only honoured in IDLE)
//   lane_mask_i[3:0]    lane enable, bit i -> yi/ei, latched at start
//   in_valid_i          beat valid
//   in_ready_o          beat accepted this edge if in_valid_i is high
//   y3_i..y0_i          candidate lanes
//   e3_i..e0_i          golden lanes
//   busy_o              high from the cycle after start up to and incl. done
//   done_o              one-cycle pulse, score_o is final
//   score_o             accumulated error bits, held until next start
//   vec_count_o         beats accepted this run
//   perfect_o           score_o == 0, valid from done until next start
//   state_o             FSM state for debug/observation
// ---------------------------------------------------------------------------
module ge_fitness_scoreboard #(
   parameter int  WIDTH   = 16,
   parameter int  NUM_VEC = 64,
   parameter int  SCORE_W = 24,
   localparam int VC_W    = $clog2(NUM_VEC + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic [3:0]         lane_mask_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [WIDTH-1:0]   y3_i,
   input  logic [WIDTH-1:0]   y2_i,
   input  logic [WIDTH-1:0]   y1_i,
   input  logic [WIDTH-1:0]   y0_i,
   input  logic [WIDTH-1:0]   e3_i,
   input  logic [WIDTH-1:0]   e2_i,
   input  logic [WIDTH-1:0]   e1_i,
   input  logic [WIDTH-1:0]   e0_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [SCORE_W-1:0] score_o,
   output logic [VC_W-1:0]    vec_count_o,
   output logic               perfect_o,
   output logic [1:0]         state_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Popcount of four lanes spans 0..4*WIDTH.
   localparam int POP_W = $clog2(4 * WIDTH + 1);
   // One spare bit above the wider operand so the add never wraps before
   // the saturation compare.
   localparam int SUM_W = ((SCORE_W > POP_W) ? SCORE_W : POP_W) + 1;

   logic [1:0]              state_q, state_d;
   logic [VC_W-1:0]         vec_count_q, vec_count_d;
   logic [3:0]              mask_q, mask_d;
   logic [SCORE_W-1:0]      score_q, score_d;
   logic                    perfect_q, perfect_d;

   logic                    s1_valid_q;
   logic [3:0][WIDTH-1:0]   s1_diff_q, s1_diff_d;
   logic                    s2_valid_q;
   logic [POP_W-1:0]        pop_q, pop_d;

   logic                    accept;
   logic                    start_acc;
   logic [3:0][WIDTH-1:0]   y_lanes, e_lanes;
   logic [SUM_W-1:0]        sum_w;
   logic [SUM_W-1:0]        sat_lim;

   assign y_lanes = {y3_i, y2_i, y1_i, y0_i};
   assign e_lanes = {e3_i, e2_i, e1_i, e0_i};

   // In RUN the count is always below NUM_VEC (the last accept leaves RUN),
   // the compare keeps ready safe regardless.
   assign in_ready_o = (state_q == ST_RUN) && (vec_count_q < VC_W'(NUM_VEC));
   assign accept     = in_valid_i && in_ready_o;
   assign start_acc  = (state_q == ST_IDLE) && start_i;

   // Stage 1: masked per-lane difference, using the mask latched at start.
   always_comb begin
      s1_diff_d = '0;
      for (int l = 0; l < 4; l++) begin
         s1_diff_d[l] = (y_lanes[l] ^ e_lanes[l]) & {WIDTH{mask_q[l]}};
      end
   end

   // Stage 2: total number of differing bits across the four lanes.
   always_comb begin
      pop_d = '0;
      for (int l = 0; l < 4; l++) begin
         for (int b = 0; b < WIDTH; b++) begin
            pop_d = pop_d + POP_W'(s1_diff_q[l][b]);
         end
      end
   end

   // Accumulator with saturation at the all-ones score.
   assign sum_w   = SUM_W'(score_q) + SUM_W'(pop_q);
   assign sat_lim = SUM_W'({SCORE_W{1'b1}});

   always_comb begin
      score_d = score_q;
      if (start_acc) begin
         score_d = '0;
      end else if (s2_valid_q) begin
         score_d = (sum_w > sat_lim) ? {SCORE_W{1'b1}} : sum_w[SCORE_W-1:0];
      end
   end

   // Control FSM and run bookkeeping.
   always_comb begin
      state_d     = state_q;
      vec_count_d = vec_count_q;
      mask_d      = mask_q;
      perfect_d   = perfect_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d     = ST_RUN;
               vec_count_d = '0;
               mask_d      = lane_mask_i;
               perfect_d   = 1'b0;
            end
         end
         ST_RUN: begin
            if (accept) begin
               vec_count_d = vec_count_q + VC_W'(1);
               if (vec_count_q == VC_W'(NUM_VEC - 1)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // Once both stages are empty the last pop is already in score_q.
            if (!s1_valid_q && !s2_valid_q) begin
               state_d   = ST_DONE;
               perfect_d = (score_q == '0);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         vec_count_q <= '0;
         mask_q      <= '0;
         score_q     <= '0;
         perfect_q   <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_diff_q   <= '0;
         s2_valid_q  <= 1'b0;
         pop_q       <= '0;
      end else begin
         state_q     <= state_d;
         vec_count_q <= vec_count_d;
         mask_q      <= mask_d;
         score_q     <= score_d;
         perfect_q   <= perfect_d;
         s1_valid_q  <= accept;
         if (accept) begin
            s1_diff_q <= s1_diff_d;
         end
         s2_valid_q  <= s1_valid_q;
         if (s1_valid_q) begin
            pop_q <= pop_d;
         end
      end
   end

   assign busy_o      = (state_q != ST_IDLE);
   assign done_o      = (state_q == ST_DONE);
   assign score_o     = score_q;
   assign vec_count_o = vec_count_q;
   assign perfect_o   = perfect_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_ge_fitness_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_ge_fitness_scoreboard
//
// Main DUT (64 beats, 24-bit score) is driven run by run. For every run the
// driver computes the expected final score from the lane rules (masked XOR
// popcount summed over the run, saturated) and pushes it into exp_q. A
// monitor pops and compares whenever done is seen. A second small instance
// (4 beats, 4-bit score) exercises saturation and ignored start pulses.
// ---------------------------------------------------------------------------
module tb_ge_fitness_scoreboard;

   localparam int WIDTH   = 16;
   localparam int NUM_VEC = 64;
   localparam int SCORE_W = 24;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- main DUT ----------------
   logic               start_i;
   logic [3:0]         lane_mask_i;
   logic               in_valid_i;
   logic               in_ready_o;
   logic [WIDTH-1:0]   ty [4];
   logic [WIDTH-1:0]   te [4];
   logic               busy_o;
   logic               done_o;
   logic [SCORE_W-1:0] score_o;
   logic [6:0]         vec_count_o;
   logic               perfect_o;
   logic [1:0]         state_o;

   ge_fitness_scoreboard #(.WIDTH(WIDTH), .NUM_VEC(NUM_VEC), .SCORE_W(SCORE_W)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .lane_mask_i(lane_mask_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .y3_i(ty[3]), .y2_i(ty[2]), .y1_i(ty[1]), .y0_i(ty[0]),
      .e3_i(te[3]), .e2_i(te[2]), .e1_i(te[1]), .e0_i(te[0]),
      .busy_o(busy_o), .done_o(done_o), .score_o(score_o),
      .vec_count_o(vec_count_o), .perfect_o(perfect_o), .state_o(state_o)
   );

   // ---------------- small DUT ----------------
   logic             s_start;
   logic             s_in_valid;
   logic             s_in_ready;
   logic [WIDTH-1:0] s_y;
   logic [WIDTH-1:0] s_e;
   logic             s_busy;
   logic             s_done;
   logic [3:0]       s_score;
   logic [2:0]       s_vec_count;
   logic             s_perfect;
   logic [1:0]       s_state;

   ge_fitness_scoreboard #(.WIDTH(WIDTH), .NUM_VEC(4), .SCORE_W(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .start_i(s_start), .lane_mask_i(4'hF),
      .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
      .y3_i(s_y), .y2_i(s_y), .y1_i(s_y), .y0_i(s_y),
      .e3_i(s_e), .e2_i(s_e), .e1_i(s_e), .e0_i(s_e),
      .busy_o(s_busy), .done_o(s_done), .score_o(s_score),
      .vec_count_o(s_vec_count), .perfect_o(s_perfect), .state_o(s_state)
   );

   // ---------------- scoreboard ----------------
   logic [SCORE_W-1:0] exp_q [$];
   logic               exp_perf_q [$];
   int                 n_checks;
   int                 n_fail;
   int                 n_done;
   int                 n_runs;
   time                last_acc_t;
   logic               done_prev;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compare every done pulse against the oldest expected run.
   always @(negedge clk) begin
      if (rst_n && done_o) begin
         n_done++;
         check("done_single_cycle", {31'd0, done_prev}, 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            logic [SCORE_W-1:0] es;
            logic               ep;
            es = exp_q.pop_front();
            ep = exp_perf_q.pop_front();
            check("score", 32'(score_o), 32'(es));
            check("perfect", 32'(perfect_o), 32'(ep));
            check("vec_count", 32'(vec_count_o), NUM_VEC);
            check("done_latency_ge3", 32'(($time - last_acc_t) >= 35), 32'd1);
         end
      end
      done_prev = rst_n && done_o;
   end

   // ---------------- driver tasks ----------------
   task automatic wait_idle();
      int k;
      k = 0;
      @(negedge clk);
      while ((busy_o || done_o) && k < 400) begin
         @(negedge clk);
         k++;
      end
      if (k >= 400) check("wait_idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic start_run(input logic [3:0] mask);
      start_i     = 1'b1;
      lane_mask_i = mask;
      @(posedge clk);
      #1;
      start_i     = 1'b0;
      // Mask changes after start must not affect this run.
      lane_mask_i = 4'($urandom);
   endtask

   task automatic send_beat(input logic [WIDTH-1:0] y [4], input logic [WIDTH-1:0] e [4]);
      int k;
      for (int l = 0; l < 4; l++) begin
         ty[l] = y[l];
         te[l] = e[l];
      end
      in_valid_i = 1'b1;
      k = 0;
      @(negedge clk);
      while (!in_ready_o && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) check("ready_timeout", 32'd1, 32'd0);
      @(posedge clk);
      last_acc_t = $time;
      #1;
      in_valid_i = 1'b0;
      for (int l = 0; l < 4; l++) begin
         ty[l] = WIDTH'($urandom);
         te[l] = WIDTH'($urandom);
      end
   endtask

   // mode: 0 random, 1 y==e, 2 y=FFFF e=0, 3 lane0 diff 3 others all-ones,
   //       4 one error bit in lane0 only
   // gap:  0 none, 1 toggle, 2 random 0..2 idle cycles
   task automatic run_main(input int mode, input logic [3:0] mask, input int gap,
                           input bit poke_start, input int beats);
      logic [WIDTH-1:0] y [4];
      logic [WIDTH-1:0] e [4];
      longint           exp_sum;
      wait_idle();
      start_run(mask);
      exp_sum = 0;
      for (int i = 0; i < beats; i++) begin
         for (int l = 0; l < 4; l++) begin
            e[l] = WIDTH'($urandom);
            case (mode)
               0: y[l] = WIDTH'($urandom);
               1: y[l] = e[l];
               2: begin y[l] = 16'hFFFF; e[l] = 16'h0000; end
               3: y[l] = (l == 0) ? (e[l] ^ 16'h0003) : ~e[l];
               default: y[l] = (l == 0) ? (e[l] ^ WIDTH'(1 << $urandom_range(0, 15))) : e[l];
            endcase
            if (mask[l]) exp_sum += $countones(y[l] ^ e[l]);
         end
         if (poke_start) start_i = 1'($urandom);
         send_beat(y, e);
         start_i = 1'b0;
         if (gap == 1) begin
            @(posedge clk); #1;
         end else if (gap == 2) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         end
      end
      if (beats == NUM_VEC) begin
         if (gap == 0) @(negedge clk);
         check("ready_low_after_last", 32'(in_ready_o), 32'd0);
         if (exp_sum > longint'({SCORE_W{1'b1}})) exp_sum = longint'({SCORE_W{1'b1}});
         exp_q.push_back(SCORE_W'(exp_sum));
         exp_perf_q.push_back(exp_sum == 0);
         n_runs++;
         wait_idle();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready_o), 32'd0);
      check({tag, "_busy"}, 32'(busy_o), 32'd0);
      check({tag, "_done"}, 32'(done_o), 32'd0);
      check({tag, "_score"}, 32'(score_o), 32'd0);
      check({tag, "_vec_count"}, 32'(vec_count_o), 32'd0);
      check({tag, "_perfect"}, 32'(perfect_o), 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      n_checks = 0; n_fail = 0; n_done = 0; n_runs = 0;
      last_acc_t = 0; done_prev = 1'b0;
      rst_n = 1'b0; start_i = 1'b0; lane_mask_i = 4'h0; in_valid_i = 1'b0;
      s_start = 1'b0; s_in_valid = 1'b0; s_y = '0; s_e = '0;
      for (int l = 0; l < 4; l++) begin ty[l] = '0; te[l] = '0; end
      #1;
      check_reset_outputs("por");
      #20;
      @(negedge clk);
      rst_n = 1'b1;

      // Reset in the middle of a run: outputs clear, no done follows.
      run_main(2, 4'hF, 0, 1'b0, 10);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrun_rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("midrun_no_restart_busy", 32'(busy_o), 32'd0);

      run_main(1, 4'hF, 0, 1'b0, NUM_VEC);     // perfect run
      run_main(2, 4'hF, 0, 1'b0, NUM_VEC);     // 4096
      run_main(3, 4'b0001, 0, 1'b0, NUM_VEC);  // 128
      run_main(4, 4'hF, 1, 1'b0, NUM_VEC);     // 64, toggled valid
      run_main(0, 4'h0, 2, 1'b0, NUM_VEC);     // mask 0 -> 0
      for (int r = 0; r < 4; r++) begin
         run_main(0, 4'($urandom), 2, 1'b1, NUM_VEC);
      end

      // Small instance: saturation and ignored start in RUN and DONE.
      begin
         int k;
         @(negedge clk);
         s_start    = 1'b1;   // held through RUN, must be ignored there
         s_y        = 16'hFFFF;
         s_e        = 16'h0000;
         s_in_valid = 1'b1;
         k = 0;
         @(negedge clk);
         while (!s_done && k < 100) begin
            @(negedge clk);
            k++;
         end
         check("s_done_seen", 32'(s_done), 32'd1);
         check("s_score_sat", 32'(s_score), 32'd15);
         check("s_perfect", 32'(s_perfect), 32'd0);
         check("s_vec_count", 32'(s_vec_count), 32'd4);
         @(posedge clk);      // start still high on the edge leaving DONE
         #1;
         s_start    = 1'b0;
         s_in_valid = 1'b0;
         @(negedge clk);
         check("s_idle_after_done", 32'(s_busy), 32'd0);
         @(negedge clk);
         check("s_still_idle", 32'(s_busy), 32'd0);
         check("s_score_held", 32'(s_score), 32'd15);
      end

      repeat (5) @(negedge clk);
      check("runs_completed", 32'(n_done), 32'(n_runs));
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
